spi_reg_writer: RTL and testbench



---
 rtl/spi_reg_writer.sv | 194 +++++++++++++++++++
 tb/tb_spi_reg_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 controller that emits 16-bit register write
// frames {rw, addr[6:0], data[7:0]}, MSB first.
// Optional build macro SPI_READ_EN adds rw/cipo/rdata for read frames;
// without it every frame is a write (bit15 = 1).
module spi_reg_writer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
`ifdef SPI_READ_EN
    input  logic       rw,
    input  logic       cipo,
    output logic [7:0] rdata,
`endif
    output logic       ncs
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'd15;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] half_cnt, half_cnt_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    // Holds frame bits 14..0; bit 15 goes straight to copi on accept.
    logic [14:0]   shreg, shreg_n;
    logic          sclk_n, copi_n, ncs_n, ready_n, busy_n, done_n;
    logic          frame_b15;
    logic          half_last;

`ifdef SPI_READ_EN
    logic       rw_q, rw_n;
    logic [7:0] rx_sh, rx_n;
    logic [7:0] rdata_n;
    assign frame_b15 = rw;
`else
    assign frame_b15 = 1'b1;
`endif

    assign half_last = (half_cnt == HALF_LAST);

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sclk     <= 1'b0;
            copi     <= 1'b0;
            ncs      <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SPI_READ_EN
            rw_q     <= 1'b0;
            rx_sh    <= '0;
            rdata    <= '0;
`endif
        end else begin
            state    <= state_n;
            half_cnt <= half_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            sclk     <= sclk_n;
            copi     <= copi_n;
            ncs      <= ncs_n;
            ready    <= ready_n;
            busy     <= busy_n;
            done     <= done_n;
`ifdef SPI_READ_EN
            rw_q     <= rw_n;
            rx_sh    <= rx_n;
            rdata    <= rdata_n;
`endif
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_n    = state;
        half_cnt_n = half_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        sclk_n     = sclk;
        copi_n     = copi;
        ncs_n      = ncs;
        ready_n    = ready;
        busy_n     = busy;
        done_n     = 1'b0;
`ifdef SPI_READ_EN
        rw_n       = rw_q;
        rx_n       = rx_sh;
        rdata_n    = rdata;
`endif

        case (state)
            IDLE: begin
                if (start && ready) begin
                    state_n    = SETUP;
                    shreg_n    = {addr, wdata};
                    copi_n     = frame_b15;
                    ncs_n      = 1'b0;
                    sclk_n     = 1'b0;
                    ready_n    = 1'b0;
                    busy_n     = 1'b1;
                    half_cnt_n = '0;
                    bit_cnt_n  = '0;
`ifdef SPI_READ_EN
                    rw_n       = rw;
                    rx_n       = '0;
`endif
                end
            end

            SETUP: begin
                if (half_last) begin
                    state_n    = SHIFT;
                    sclk_n     = 1'b1;
                    half_cnt_n = '0;
                end else begin
                    half_cnt_n = half_cnt + CW'(1);
                end
            end

            SHIFT: begin
                if (!half_last) begin
                    half_cnt_n = half_cnt + CW'(1);
                end else begin
                    half_cnt_n = '0;
                    if (sclk) begin
                        // Falling edge: present the next bit unless this was the last one.
                        sclk_n = 1'b0;
                        if (bit_cnt != BIT_LAST) begin
                            copi_n  = shreg[14];
                            shreg_n = {shreg[13:0], 1'b0};
                        end
                    end else if (bit_cnt == BIT_LAST) begin
                        // Hold half after the 16th fall has elapsed.
                        state_n = GAP;
                        ncs_n   = 1'b1;
                    end else begin
                        sclk_n    = 1'b1;
                        bit_cnt_n = bit_cnt + 5'd1;
`ifdef SPI_READ_EN
                        // Rising edges for bits 8..15 carry the read byte.
                        if (bit_cnt >= 5'd7) begin
                            rx_n = {rx_sh[6:0], cipo};
                        end
`endif
                    end
                end
            end

            GAP: begin
                if (half_last) begin
                    state_n    = IDLE;
                    half_cnt_n = '0;
                    done_n     = 1'b1;
                    ready_n    = 1'b1;
                    busy_n     = 1'b0;
                    copi_n     = 1'b0;
`ifdef SPI_READ_EN
                    if (!rw_q) begin
                        rdata_n = rx_sh;
                    end
`endif
                end else begin
                    half_cnt_n = half_cnt + CW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: one instance at CLK_DIV=4 and one at
// CLK_DIV=2, frame capture on sclk rises, table of write frames plus
// hand-written back-to-back, start-while-busy, reset and read sequences.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [6:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ready_a, busy_a, done_a, sclk_a, copi_a, ncs_a;
    logic       ready_b, busy_b, done_b, sclk_b, copi_b, ncs_b;
`ifdef SPI_READ_EN
    logic       rw_a = 1'b1, rw_b = 1'b1;
    logic       cipo_a, cipo_b;
    logic [7:0] rdata_a, rdata_b;
    logic [7:0] resp = 8'h00;
    logic [15:0] resp16;
    int         fall_cnt = 0;
`endif

    // sel chooses which instance the tasks drive and observe: 0 -> div 4, 1 -> div 2
    logic sel = 1'b0;
    logic m_ready, m_busy, m_done, m_sclk, m_copi, m_ncs;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // Results of the last run_frame call.
    logic [15:0] r_frame;
    int          r_done_cyc, r_ncs_low, r_rises, r_done_cnt;
    logic        r_rdy_done, r_busy_done, r_copi_done;
    logic [7:0]  r_rdata_done;

    spi_reg_writer #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .addr(addr_a), .wdata(wdata_a),
        .ready(ready_a), .busy(busy_a), .done(done_a), .sclk(sclk_a), .copi(copi_a),
`ifdef SPI_READ_EN
        .rw(rw_a), .cipo(cipo_a), .rdata(rdata_a),
`endif
        .ncs(ncs_a)
    );

    spi_reg_writer #(.CLK_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .addr(addr_b), .wdata(wdata_b),
        .ready(ready_b), .busy(busy_b), .done(done_b), .sclk(sclk_b), .copi(copi_b),
`ifdef SPI_READ_EN
        .rw(rw_b), .cipo(cipo_b), .rdata(rdata_b),
`endif
        .ncs(ncs_b)
    );

    always #5 clk = ~clk;

    assign m_ready = sel ? ready_b : ready_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_sclk  = sel ? sclk_b  : sclk_a;
    assign m_copi  = sel ? copi_b  : copi_a;
    assign m_ncs   = sel ? ncs_b   : ncs_a;

`ifdef SPI_READ_EN
    // Peripheral model: shifts out resp on frame positions 8..15, changing on sclk falls.
    assign resp16 = {8'h00, resp};
    always @(negedge sclk_a or posedge ncs_a) begin
        if (ncs_a) fall_cnt <= 0;
        else       fall_cnt <= fall_cnt + 1;
    end
    assign cipo_a = (!ncs_a && fall_cnt >= 8 && fall_cnt < 16) ? resp16[15 - fall_cnt] : 1'b0;
    assign cipo_b = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic s, input logic [6:0] a, input logic [7:0] d);
        if (sel) begin
            start_b = s; addr_b = a; wdata_b = d;
        end else begin
            start_a = s; addr_a = a; wdata_a = d;
        end
    endtask

    // Issue one frame, scramble addr/wdata after accept, optionally re-pulse
    // start at cycle inj, and observe 300 cycles after the accept edge.
    task automatic run_frame(input logic [6:0] a, input logic [7:0] d, input int inj);
        int   w;
        logic prev_sclk;
        set_inputs(1'b1, a, d);
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (m_ready && w < 8);
        check("accept", 32'(m_ready), 32'd0);
        set_inputs(1'b0, ~a, ~d);
        r_frame = '0; r_rises = 0; r_done_cnt = 0; r_done_cyc = -1;
        r_ncs_low = m_ncs ? 0 : 1;
        r_rdy_done = 1'b0; r_busy_done = 1'b1; r_copi_done = 1'b1; r_rdata_done = '0;
        prev_sclk = m_sclk;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (inj > 0 && cyc == inj)     set_inputs(1'b1, 7'h7F, ~d);
            if (inj > 0 && cyc == inj + 1) set_inputs(1'b0, 7'h7F, ~d);
            if (!m_ncs) r_ncs_low++;
            if (!prev_sclk && m_sclk) begin
                r_frame = {r_frame[14:0], m_copi};
                r_rises++;
            end
            prev_sclk = m_sclk;
            if (m_done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc  = cyc;
                    r_rdy_done  = m_ready;
                    r_busy_done = m_busy;
                    r_copi_done = m_copi;
`ifdef SPI_READ_EN
                    r_rdata_done = sel ? rdata_b : rdata_a;
`endif
                end
            end
        end
    endtask

    typedef struct {
        logic        sel;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] frame;
        int          done_cyc;
        int          ncs_low;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_rdy, prev_sclk;
        logic [15:0] fr0, fr1;
        int          acc, gap, dcnt, w;

        // done = 34*CLK_DIV cycles after accept, ncs low for 33*CLK_DIV samples
        tbl[0] = '{1'b0, 7'h04, 8'hA5, 16'h84A5, 136, 132};
        tbl[1] = '{1'b0, 7'h55, 8'h3C, 16'hD53C, 136, 132};
        tbl[2] = '{1'b0, 7'h00, 8'h00, 16'h8000, 136, 132};
        tbl[3] = '{1'b1, 7'h7F, 8'h00, 16'hFF00,  68,  66};
        tbl[4] = '{1'b1, 7'h2A, 8'hC3, 16'hAAC3,  68,  66};

        start_a = 1'b0; addr_a = '0; wdata_a = '0;
        start_b = 1'b0; addr_b = '0; wdata_b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  32'(ready_a), 32'd1);
        check("rst_busy",   32'(busy_a),  32'd0);
        check("rst_done",   32'(done_a),  32'd0);
        check("rst_sclk",   32'(sclk_a),  32'd0);
        check("rst_copi",   32'(copi_a),  32'd0);
        check("rst_ncs",    32'(ncs_a),   32'd1);
        check("rst_ready_b", 32'(ready_b), 32'd1);
        check("rst_ncs_b",   32'(ncs_b),   32'd1);
`ifdef SPI_READ_EN
        check("rst_rdata",  32'(rdata_a), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of single write frames
        for (int i = 0; i < 5; i++) begin
            sel = tbl[i].sel;
            run_frame(tbl[i].addr, tbl[i].wdata, 0);
            check("frame",      32'(r_frame),     32'(tbl[i].frame));
            check("rises",      32'(r_rises),     32'd16);
            check("done_cyc",   32'(r_done_cyc),  32'(tbl[i].done_cyc));
            check("ncs_low",    32'(r_ncs_low),   32'(tbl[i].ncs_low));
            check("done_cnt",   32'(r_done_cnt),  32'd1);
            check("ready_done", 32'(r_rdy_done),  32'd1);
            check("busy_done",  32'(r_busy_done), 32'd0);
            check("copi_done",  32'(r_copi_done), 32'd0);
        end

        // Back-to-back: start held high through the done cycle
        sel = 1'b0;
        set_inputs(1'b1, 7'h00, 8'hFF);
        prev_rdy = m_ready; prev_sclk = m_sclk;
        fr0 = '0; fr1 = '0; acc = 0; gap = 0; dcnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (prev_rdy && !m_ready) begin
                acc++;
                if (acc == 1) set_inputs(1'b1, 7'h01, 8'h0F);
                else          set_inputs(1'b0, 7'h01, 8'h0F);
            end
            prev_rdy = m_ready;
            if (!prev_sclk && m_sclk) begin
                if (acc == 1) fr0 = {fr0[14:0], m_copi};
                if (acc == 2) fr1 = {fr1[14:0], m_copi};
            end
            prev_sclk = m_sclk;
            if (acc == 1 && m_ncs) gap++;
            if (m_done) dcnt++;
        end
        check("b2b_accepts", 32'(acc),  32'd2);
        check("b2b_frame0",  32'(fr0),  32'h80FF);
        check("b2b_frame1",  32'(fr1),  32'h810F);
        // CLK_DIV gap cycles plus the done cycle in which the next start is taken
        check("b2b_ncs_gap", 32'(gap),  32'd5);
        check("b2b_dones",   32'(dcnt), 32'd2);

        // Start re-pulsed mid-frame with a different address
        sel = 1'b0;
        run_frame(7'h12, 8'h34, 20);
        check("busy_start_frame", 32'(r_frame),    32'h9234);
        check("busy_start_dones", 32'(r_done_cnt), 32'd1);
        check("busy_start_cyc",   32'(r_done_cyc), 32'd136);

        // Reset after the 7th sclk rise
        sel = 1'b0;
        set_inputs(1'b1, 7'h11, 8'h22);
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (m_ready && w < 8);
        set_inputs(1'b0, 7'h11, 8'h22);
        acc = 0; prev_sclk = m_sclk; w = 0;
        while (acc < 7 && w < 200) begin
            @(posedge clk); #1;
            w++;
            if (!prev_sclk && m_sclk) acc++;
            prev_sclk = m_sclk;
        end
        check("rst_mid_rises", 32'(acc), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstm_ncs",   32'(ncs_a),   32'd1);
        check("rstm_sclk",  32'(sclk_a),  32'd0);
        check("rstm_copi",  32'(copi_a),  32'd0);
        check("rstm_ready", 32'(ready_a), 32'd1);
        check("rstm_busy",  32'(busy_a),  32'd0);
        dcnt = 0; gap = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(posedge clk); #1;
            if (done_a) dcnt++;
            if (!ncs_a) gap++;
        end
        check("rstm_no_done",   32'(dcnt), 32'd0);
        check("rstm_ncs_idle",  32'(gap),  32'd0);
        run_frame(7'h02, 8'h3C, 0);
        check("rstm_next_frame", 32'(r_frame),    32'h823C);
        check("rstm_next_done",  32'(r_done_cyc), 32'd136);

`ifdef SPI_READ_EN
        // Read frame: peripheral returns 0x5A in the data byte
        sel = 1'b0;
        rw_a = 1'b0; resp = 8'h5A;
        run_frame(7'h04, 8'h00, 0);
        check("rd_frame_hi", 32'(r_frame[15:8]), 32'h04);
        check("rd_rdata",    32'(r_rdata_done),  32'h5A);
        check("rd_done_cyc", 32'(r_done_cyc),    32'd136);
        rw_a = 1'b1; resp = 8'hC3;
        run_frame(7'h03, 8'h77, 0);
        check("wr_frame",      32'(r_frame),      32'h8377);
        check("wr_rdata_hold", 32'(r_rdata_done), 32'h5A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
